race_sequencer: RTL and testbench
=================================

RACE_SEQUENCER -- requirements
Module: race_sequencer

Interface
REQ-001 SHALL have parameter COUNT_FRAMES, default 180, countdown length in frame ticks (1..255).
REQ-002 SHALL have parameter LAPS_TO_WIN, default 3, laps required to win (1..7).
REQ-003 SHALL have parameter RESYNC_FRAMES, default 120, resync timeout in frame ticks (1..255).
REQ-004 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-005 SHALL have port btnc  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start_btn  input  1  debounced start/restart button level.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port lap_cross  input  1  one-cycle pulse: player crossed finish line in correct direction.
REQ-009 SHALL have port opp_valid  input  1  opp_status is a fresh received value this cycle.
REQ-010 SHALL have port opp_status  input  3  opponent status code, same encoding as my_status.
REQ-011 SHALL have port my_status  output  3  0 idle, 1 ready, 2 won, 3 racing, 4 lost, 5 resync.
REQ-012 SHALL have port state  output  3  FSM state: 0 IDLE, 1 READY, 2 COUNTDOWN, 3 RACE, 4 FINISH, 5 RESYNC.
REQ-013 SHALL have port laps  output  3  completed laps.
REQ-014 SHALL have port cd_frames  output  8  countdown frames remaining.
REQ-015 SHALL have ports move_en, load_start, won, lost  output  1 each  kinematics update strobe, start-position load strobe, win flag, loss flag.

Function
REQ-016 All outputs SHALL be registered; "start_rise" SHALL mean start_btn=1 this cycle and registered previous start_btn=0.
REQ-017 IDLE: my_status=0; start_rise -> READY next cycle.
REQ-018 READY: my_status=1; start_btn=0 -> IDLE; else opp_valid=1 with opp_status=1 -> COUNTDOWN, cd_frames=COUNT_FRAMES, load_start=1 for exactly one cycle (the first COUNTDOWN cycle).
REQ-019 COUNTDOWN: my_status=1; each frame_tick decrements cd_frames; frame_tick with cd_frames=1 -> RACE with cd_frames=0; start_btn ignored.
REQ-020 RACE: my_status=3; move_en SHALL equal frame_tick delayed one cycle, and SHALL be 0 in every other state.
REQ-021 RACE: lap_cross increments laps; lap_cross with laps=LAPS_TO_WIN-1 -> FINISH with laps=LAPS_TO_WIN, won=1.
REQ-022 RACE: opp_valid=1 with opp_status=2 -> FINISH with lost=1, laps unchanged.
REQ-023 Simultaneous winning lap_cross and opponent-won SHALL resolve as won=1, lost=0.
REQ-024 laps SHALL never exceed LAPS_TO_WIN; lap_cross outside RACE SHALL be ignored.
REQ-025 FINISH: my_status=2 if won else 4; won/lost held; start_rise -> RESYNC with internal counter=RESYNC_FRAMES.
REQ-026 RESYNC: my_status=5; opp_valid=1 with opp_status in {0,1,5} -> IDLE; else each frame_tick decrements counter and frame_tick with counter=1 -> IDLE (timeout).
REQ-027 Entry to IDLE from RESYNC SHALL clear laps, won, lost, cd_frames in the same edge.
REQ-028 opp_status SHALL be ignored whenever opp_valid=0; unlisted opp_status values SHALL cause no transition.
REQ-029 won and lost SHALL never both be 1.

Reset
REQ-030 btnc=1 SHALL immediately force state=IDLE, my_status=0, laps=0, cd_frames=0, move_en=0, load_start=0, won=0, lost=0, start history=0, resync counter=0, from any state including mid-countdown or mid-race.
REQ-031 After btnc deasserts, a start_btn already held high SHALL NOT produce start_rise until released and pressed again.

Verification
REQ-032 Start: start_btn rises in IDLE, opp_valid with opp_status=1 two cycles later -> READY then COUNTDOWN, load_start one-cycle pulse, cd_frames=180.
REQ-033 Countdown (COUNT_FRAMES=3): three frame_ticks -> cd_frames 2,1,0, state=3, my_status=3; next frame_tick -> move_en pulse one cycle later.
REQ-034 Win: three lap_cross pulses in RACE -> laps 1,2,3, state=4, won=1, my_status=2; fourth lap_cross -> laps stays 3.
REQ-035 Simultaneous: laps=2, lap_cross and opp_valid/opp_status=2 same cycle -> won=1, lost=0, my_status=2.
REQ-036 Resync: FINISH, start_rise -> state=5, my_status=5; opp_status=5 valid -> IDLE with laps=0, won=0; separately no opponent for RESYNC_FRAMES ticks -> IDLE.
REQ-037 Reset: btnc pulse mid-RACE with laps=2 -> all outputs at reset values within the assertion cycle, without a clock edge.

Source files
------------

// File: rtl/race_sequencer.sv
// Race flow controller for a two-player racing game: start handshake, countdown,
// lap counting, win/loss arbitration and post-race resynchronisation with the opponent.
module race_sequencer #(
    parameter int COUNT_FRAMES  = 180,
    parameter int LAPS_TO_WIN   = 3,
    parameter int RESYNC_FRAMES = 120
) (
    input  logic       clk,
    input  logic       btnc,
    input  logic       start_btn,
    input  logic       frame_tick,
    input  logic       lap_cross,
    input  logic       opp_valid,
    input  logic [2:0] opp_status,
    output logic [2:0] my_status,
    output logic [2:0] state,
    output logic [2:0] laps,
    output logic [7:0] cd_frames,
    output logic       move_en,
    output logic       load_start,
    output logic       won,
    output logic       lost
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READY     = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_RACE      = 3'd3,
        S_FINISH    = 3'd4,
        S_RESYNC    = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_WON    = 3'd2,
        ST_RACING = 3'd3,
        ST_LOST   = 3'd4,
        ST_RESYNC = 3'd5
    } status_t;

    localparam logic [2:0] LAPS_WIN  = 3'(LAPS_TO_WIN);
    localparam logic [2:0] LAPS_LAST = 3'(LAPS_TO_WIN - 1);
    localparam logic [7:0] CD_INIT   = 8'(COUNT_FRAMES);
    localparam logic [7:0] RS_INIT   = 8'(RESYNC_FRAMES);

    state_t     r_state,  w_state_nxt;
    status_t    r_status, w_status_nxt;
    logic [2:0] r_laps,   w_laps_nxt;
    logic [7:0] r_cd,     w_cd_nxt;
    logic [7:0] r_resync, w_resync_nxt;
    logic       r_move_en, w_move_nxt;
    logic       r_load,    w_load_nxt;
    logic       r_won,     w_won_nxt;
    logic       r_lost,    w_lost_nxt;
    logic       r_start_prev;
    logic       r_start_armed;

    logic w_start_rise;
    logic w_opp_ready;
    logic w_opp_won;
    logic w_opp_back;

    // Armed only once start_btn has been seen low since reset, so a held button cannot fire.
    assign w_start_rise = start_btn & ~r_start_prev & r_start_armed;
    assign w_opp_ready  = opp_valid && (opp_status == 3'd1);
    assign w_opp_won    = opp_valid && (opp_status == 3'd2);
    assign w_opp_back   = opp_valid && ((opp_status == 3'd0) || (opp_status == 3'd1) ||
                                        (opp_status == 3'd5));

    always_comb begin
        w_state_nxt  = r_state;
        w_laps_nxt   = r_laps;
        w_cd_nxt     = r_cd;
        w_resync_nxt = r_resync;
        w_won_nxt    = r_won;
        w_lost_nxt   = r_lost;
        w_load_nxt   = 1'b0;
        w_move_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_start_rise) w_state_nxt = S_READY;
            end
            S_READY: begin
                if (!start_btn) begin
                    w_state_nxt = S_IDLE;
                end else if (w_opp_ready) begin
                    w_state_nxt = S_COUNTDOWN;
                    w_cd_nxt    = CD_INIT;
                    w_load_nxt  = 1'b1;
                end
            end
            S_COUNTDOWN: begin
                if (frame_tick) begin
                    w_cd_nxt = r_cd - 8'd1;
                    if (r_cd == 8'd1) w_state_nxt = S_RACE;
                end
            end
            S_RACE: begin
                // Winning lap beats a simultaneous opponent win; a loss freezes the lap count.
                if (lap_cross && (r_laps == LAPS_LAST)) begin
                    w_laps_nxt  = LAPS_WIN;
                    w_won_nxt   = 1'b1;
                    w_state_nxt = S_FINISH;
                end else if (w_opp_won) begin
                    w_lost_nxt  = 1'b1;
                    w_state_nxt = S_FINISH;
                end else begin
                    if (lap_cross) w_laps_nxt = r_laps + 3'd1;
                    w_move_nxt = frame_tick;
                end
            end
            S_FINISH: begin
                if (w_start_rise) begin
                    w_state_nxt  = S_RESYNC;
                    w_resync_nxt = RS_INIT;
                end
            end
            S_RESYNC: begin
                if (!w_opp_back && frame_tick) w_resync_nxt = r_resync - 8'd1;
                if (w_opp_back || (frame_tick && (r_resync == 8'd1))) begin
                    w_state_nxt  = S_IDLE;
                    w_laps_nxt   = '0;
                    w_cd_nxt     = '0;
                    w_resync_nxt = '0;
                    w_won_nxt    = 1'b0;
                    w_lost_nxt   = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        case (w_state_nxt)
            S_IDLE:      w_status_nxt = ST_IDLE;
            S_READY:     w_status_nxt = ST_READY;
            S_COUNTDOWN: w_status_nxt = ST_READY;
            S_RACE:      w_status_nxt = ST_RACING;
            S_FINISH:    w_status_nxt = w_won_nxt ? ST_WON : ST_LOST;
            S_RESYNC:    w_status_nxt = ST_RESYNC;
            default:     w_status_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge btnc) begin
        if (btnc) begin
            r_state       <= S_IDLE;
            r_status      <= ST_IDLE;
            r_laps        <= '0;
            r_cd          <= '0;
            r_resync      <= '0;
            r_move_en     <= 1'b0;
            r_load        <= 1'b0;
            r_won         <= 1'b0;
            r_lost        <= 1'b0;
            r_start_prev  <= 1'b0;
            r_start_armed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_status      <= w_status_nxt;
            r_laps        <= w_laps_nxt;
            r_cd          <= w_cd_nxt;
            r_resync      <= w_resync_nxt;
            r_move_en     <= w_move_nxt;
            r_load        <= w_load_nxt;
            r_won         <= w_won_nxt;
            r_lost        <= w_lost_nxt;
            r_start_prev  <= start_btn;
            r_start_armed <= r_start_armed | ~start_btn;
        end
    end

    assign state      = r_state;
    assign my_status  = r_status;
    assign laps       = r_laps;
    assign cd_frames  = r_cd;
    assign move_en    = r_move_en;
    assign load_start = r_load;
    assign won        = r_won;
    assign lost       = r_lost;

endmodule

// File: tb/tb_race_sequencer.sv
// Bench for race_sequencer: directed race scenarios followed by random stimulus,
// all compared cycle by cycle against a rule-level model of the race flow.
module tb_race_sequencer;

    localparam int CF = 3;
    localparam int LW = 3;
    localparam int RF = 5;

    logic       clk = 1'b0;
    logic       btnc;
    logic       start_btn;
    logic       frame_tick;
    logic       lap_cross;
    logic       opp_valid;
    logic [2:0] opp_status;
    logic [2:0] my_status;
    logic [2:0] state;
    logic [2:0] laps;
    logic [7:0] cd_frames;
    logic       move_en;
    logic       load_start;
    logic       won;
    logic       lost;

    race_sequencer #(
        .COUNT_FRAMES (CF),
        .LAPS_TO_WIN  (LW),
        .RESYNC_FRAMES(RF)
    ) dut (
        .clk       (clk),
        .btnc      (btnc),
        .start_btn (start_btn),
        .frame_tick(frame_tick),
        .lap_cross (lap_cross),
        .opp_valid (opp_valid),
        .opp_status(opp_status),
        .my_status (my_status),
        .state     (state),
        .laps      (laps),
        .cd_frames (cd_frames),
        .move_en   (move_en),
        .load_start(load_start),
        .won       (won),
        .lost      (lost)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the race: phase 0 idle, 1 ready, 2 countdown, 3 race, 4 finish, 5 resync.
    int m_phase, m_laps, m_cd, m_rs;
    bit m_won, m_lost, m_move, m_load, m_prev, m_seen_low;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    endtask

    function automatic int exp_status();
        case (m_phase)
            0:       return 0;
            1, 2:    return 1;
            3:       return 3;
            4:       return m_won ? 2 : 4;
            default: return 5;
        endcase
    endfunction

    task automatic model_reset();
        m_phase = 0; m_laps = 0; m_cd = 0; m_rs = 0;
        m_won = 0; m_lost = 0; m_move = 0; m_load = 0; m_prev = 0; m_seen_low = 0;
    endtask

    task automatic back_to_idle();
        m_phase = 0; m_laps = 0; m_cd = 0; m_rs = 0; m_won = 0; m_lost = 0;
    endtask

    // Applies the race rules to the inputs present in this cycle.
    task automatic model_step();
        bit rise;
        bit opp_rdy, opp_win, opp_back;
        rise     = start_btn && !m_prev && m_seen_low;
        opp_rdy  = opp_valid && opp_status == 3'd1;
        opp_win  = opp_valid && opp_status == 3'd2;
        opp_back = opp_valid && (opp_status == 3'd0 || opp_status == 3'd1 || opp_status == 3'd5);
        m_move = 0;
        m_load = 0;
        case (m_phase)
            0: if (rise) m_phase = 1;
            1: begin
                if (!start_btn) m_phase = 0;
                else if (opp_rdy) begin m_phase = 2; m_cd = CF; m_load = 1; end
            end
            2: if (frame_tick) begin
                m_cd = m_cd - 1;
                if (m_cd == 0) m_phase = 3;
            end
            3: begin
                if (lap_cross && m_laps + 1 == LW) begin
                    m_laps = LW; m_won = 1; m_phase = 4;
                end else if (opp_win) begin
                    m_lost = 1; m_phase = 4;
                end else begin
                    if (lap_cross) m_laps = m_laps + 1;
                    m_move = frame_tick;
                end
            end
            4: if (rise) begin m_phase = 5; m_rs = RF; end
            default: begin
                if (opp_back) back_to_idle();
                else if (frame_tick) begin
                    m_rs = m_rs - 1;
                    if (m_rs == 0) back_to_idle();
                end
            end
        endcase
        m_prev = start_btn;
        if (!start_btn) m_seen_low = 1;
    endtask

    task automatic check_all();
        check("state", int'(state), m_phase);
        check("my_status", int'(my_status), exp_status());
        check("laps", int'(laps), m_laps);
        check("cd_frames", int'(cd_frames), m_cd);
        check("move_en", int'(move_en), int'(m_move));
        check("load_start", int'(load_start), int'(m_load));
        check("won", int'(won), int'(m_won));
        check("lost", int'(lost), int'(m_lost));
        check("won_lost_excl", int'(won & lost), 0);
    endtask

    task automatic step(input bit s, input bit f, input bit l, input bit v, input logic [2:0] os);
        start_btn = s; frame_tick = f; lap_cross = l; opp_valid = v; opp_status = os;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge occurs.
    task automatic pulse_reset();
        btnc = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        btnc = 1'b0;
    endtask

    task automatic go_race();
        step(0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 1, 3'd1);
        for (int i = 0; i < CF; i++) step(1, 1, 0, 0, 3'd0);
    endtask

    initial begin
        bit rs;
        btnc = 1'b1; start_btn = 0; frame_tick = 0; lap_cross = 0; opp_valid = 0; opp_status = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        btnc = 1'b0;

        // Start handshake, countdown and first movement strobe.
        go_race();
        step(1, 1, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        // Win on laps, extra lap ignored, then resync via opponent status 5.
        for (int i = 0; i < LW + 1; i++) step(1, 0, 1, 0, 3'd0);
        step(0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 1, 3'd5);

        // Winning lap and opponent win in the same cycle.
        go_race();
        for (int i = 0; i < LW - 1; i++) step(1, 0, 1, 0, 3'd0);
        step(1, 0, 1, 1, 3'd2);
        // Resync by timeout, with an ignored invalid opponent value along the way.
        step(0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        step(1, 1, 0, 0, 3'd5);
        for (int i = 0; i < RF; i++) step(1, 1, 0, 1, 3'd7);

        // Loss, then reset mid-race with two laps while start stays held.
        go_race();
        step(1, 0, 0, 1, 3'd2);
        step(0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);
        step(1, 0, 0, 1, 3'd0);
        go_race();
        step(1, 0, 1, 0, 3'd0);
        step(1, 0, 1, 0, 3'd0);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 3'd0);
        step(0, 0, 0, 0, 3'd0);
        step(1, 0, 0, 0, 3'd0);

        // Random phase.
        rs = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) rs = ~rs;
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset();
            end else begin
                step(rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                     ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
